muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit for the riscy32 core. It sits between the register file read ports and the register file write port. It latches the two source operands (rd1/rd2) and the destination index on `start`, computes over a fixed number of cycles, then presents `result`/`rd_out` with a one-cycle `done` pulse. That pulse drives the register file's `we3`/`wd3`/`a3`.

## Interface
- No parameters; widths fixed at XLEN=32, 5-bit register index.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `start`  input  1  request; sampled only in IDLE.
- `funct3`  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  input  32  rs1 value (from rd1).
- `op_b`  input  32  rs2 value (from rd2).
- `rd_in`  input  5  destination register index.
- `busy`  output  1  high whenever state != IDLE.
- `done`  output  1  one-cycle pulse; result/rd_out valid.
- `result`  output  32  computed value, held until next accepted start.
- `rd_out`  output  5  latched `rd_in`, held until next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC on `start`.
  - CALC -> FIX after 32 iterations.
  - FIX -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
- On accept, latch `funct3`, `rd_in`, sign flags sa/sb and magnitudes |op_a|/|op_b|.
  - Signedness: MULH both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned; MUL treated unsigned (low word identical); DIV/REM signed.
  - Later changes on the operand inputs have no effect.
- 5-bit iteration counter, cleared on accept; CALC exits when it reaches 31 at an edge.
- Multiply: unsigned shift-add, one bit of |b| per iteration into a 64-bit accumulator.
- Divide: restoring, one quotient bit per iteration; 32-bit remainder with 33-bit trial subtract.
- FIX applies sign and special cases, then loads `result`:
  - MUL* : negate the 64-bit product if sa^sb. MUL takes bits [31:0]; MULH/MULHSU/MULHU take bits [63:32].
  - DIV/REM: negate quotient if sa^sb; negate remainder if sa.
  - Divide by zero (op_b==0): DIV/DIVU = 0xFFFFFFFF; REM/REMU = op_a unchanged.
  - Signed overflow (DIV, op_a=0x80000000, op_b=0xFFFFFFFF): quotient 0x80000000, remainder 0.
- All arithmetic wraps modulo 2^32 / 2^64; no exceptions or flags.
- `start` asserted while busy is ignored; no queueing.
- `rd_in`=0 is computed normally; `done` still pulses. Suppression of the write is the register file's job.

## Timing
- Reset (any time, including mid-operation): state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, counter=0.
  - The in-flight op is discarded and no `done` is issued.
  - First start may be sampled at the first rising edge after `rst` deasserts.
- Let E0 be the edge sampling `start` in IDLE:
  - `busy`=1 from E0.
  - Iterations occur on E1..E32.
  - FIX is evaluated at E33; `result`/`rd_out` update at E33.
  - `done`=1 for exactly the cycle between E33 and E34.
  - IDLE and `busy`=0 after E34.
- Latency is a fixed 33 cycles start-to-done for every funct3 and every operand value, special cases included.
- Minimum start-to-start spacing is 35 cycles. A start held high through DONE is accepted at the first edge after E34.
- `done` is never high for two consecutive cycles.

## Test plan
- MUL 7 x 6, rd_in=5: `done` 33 cycles after start; `result`=42 (0x0000002A), `rd_out`=5; `busy` low again 1 cycle later.
- MULH/MULHSU/MULHU with 0xFFFFFFFF x 0xFFFFFFFF: results 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively; MUL low word = 0x00000001.
- DIV -7/2 = 0xFFFFFFFD (-3); REM -7/2 = 0xFFFFFFFF (-1); DIVU 100/7 = 14; REMU 100/7 = 2.
- Divide by zero with op_a=0x12345678: DIV/DIVU = 0xFFFFFFFF, REM/REMU = 0x12345678; overflow DIV 0x80000000/0xFFFFFFFF = 0x80000000, REM = 0.
- Second `start` pulsed at cycle 10 of an op and operand inputs changed mid-op: first result unaffected; no second `done` until a fresh start in IDLE.
- `rst` asserted at cycle 20 of a DIV: outputs zero immediately (asynchronous); no `done` ever issued for that op; next op after reset completes correctly in 33 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide unit. Operands are latched
//                on start, 32 shift-add / restoring-divide iterations follow,
//                a fix-up cycle applies signs and special cases, then a
//                one-cycle done pulse presents result and rd_out.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [4:0]  rd_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  rd_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [2:0] c_f3_mul    = 3'b000;
   localparam logic [2:0] c_f3_mulh   = 3'b001;
   localparam logic [2:0] c_f3_mulhsu = 3'b010;
   localparam logic [2:0] c_f3_mulhu  = 3'b011;
   localparam logic [2:0] c_f3_div    = 3'b100;
   localparam logic [2:0] c_f3_divu   = 3'b101;
   localparam logic [2:0] c_f3_rem    = 3'b110;
   localparam logic [2:0] c_f3_remu   = 3'b111;

   state_t      state_q,  state_d;
   logic [4:0]  cnt_q,    cnt_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [4:0]  rd_q,     rd_d;
   logic        sa_q,     sa_d;
   logic        sb_q,     sb_d;
   logic [31:0] a_q,      a_d;      // |op_a|
   logic [31:0] b_q,      b_d;      // |op_b|
   logic [31:0] hi_q,     hi_d;     // product high word / partial remainder
   logic [31:0] lo_q,     lo_d;     // product low word (multiplier) / quotient
   logic [31:0] result_q, result_d;
   logic [4:0]  rd_out_q, rd_out_d;
   logic        done_q,   done_d;

   // Operand signedness and magnitudes for the incoming request
   logic        w_signed_a;
   logic        w_signed_b;
   logic        w_sa;
   logic        w_sb;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;

   // Per-iteration datapath
   logic [32:0] w_mul_sum;
   logic [32:0] w_div_trial;
   logic        w_div_bit;
   logic [31:0] w_div_rem;

   // Fix-up datapath
   logic [63:0] w_prod;
   logic [63:0] w_prod_s;
   logic [31:0] w_quot_s;
   logic [31:0] w_rem_s;
   logic [31:0] w_a_orig;
   logic        w_b_zero;
   logic [31:0] w_fix_result;

   // Decode which operands are treated as signed; MUL is unsigned since its low word is sign-agnostic
   always_comb begin
      w_signed_a = (funct3 == c_f3_mulh) || (funct3 == c_f3_mulhsu) ||
                   (funct3 == c_f3_div)  || (funct3 == c_f3_rem);
      w_signed_b = (funct3 == c_f3_mulh) || (funct3 == c_f3_div) ||
                   (funct3 == c_f3_rem);
      w_sa       = w_signed_a & op_a[31];
      w_sb       = w_signed_b & op_b[31];
      w_abs_a    = w_sa ? (~op_a + 32'd1) : op_a;
      w_abs_b    = w_sb ? (~op_b + 32'd1) : op_b;
   end

   // One multiply step (shift-add) and one restoring divide step
   always_comb begin
      w_mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : 33'd0);
      w_div_trial = {hi_q, lo_q[31]} - {1'b0, b_q};
      w_div_bit   = ~w_div_trial[32];
      w_div_rem   = w_div_bit ? w_div_trial[31:0] : {hi_q[30:0], lo_q[31]};
   end

   // Sign correction and divide special cases applied in the FIX cycle
   always_comb begin
      w_prod       = {hi_q, lo_q};
      w_prod_s     = (sa_q ^ sb_q) ? (~w_prod + 64'd1) : w_prod;
      w_quot_s     = (sa_q ^ sb_q) ? (~lo_q + 32'd1) : lo_q;
      w_rem_s      = sa_q ? (~hi_q + 32'd1) : hi_q;
      w_a_orig     = sa_q ? (~a_q + 32'd1) : a_q;
      w_b_zero     = (b_q == 32'd0);
      w_fix_result = 32'd0;
      case (funct3_q)
         c_f3_mul:                          w_fix_result = w_prod_s[31:0];
         c_f3_mulh, c_f3_mulhsu, c_f3_mulhu: w_fix_result = w_prod_s[63:32];
         c_f3_div, c_f3_divu:               w_fix_result = w_b_zero ? 32'hFFFF_FFFF : w_quot_s;
         c_f3_rem, c_f3_remu:               w_fix_result = w_b_zero ? w_a_orig : w_rem_s;
         default:                           w_fix_result = 32'd0;
      endcase
   end

   // Next-state and datapath register update for the IDLE/CALC/FIX/DONE sequence
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      funct3_d = funct3_q;
      rd_d     = rd_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      a_d      = a_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;
      rd_out_d = rd_out_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_CALC;
               cnt_d    = 5'd0;
               funct3_d = funct3;
               rd_d     = rd_in;
               sa_d     = w_sa;
               sb_d     = w_sb;
               a_d      = w_abs_a;
               b_d      = w_abs_b;
               hi_d     = 32'd0;
               // Divide shifts dividend bits out of lo; multiply consumes multiplier bits from lo
               lo_d     = funct3[2] ? w_abs_a : w_abs_b;
            end
         end
         ST_CALC: begin
            cnt_d = cnt_q + 5'd1;
            if (funct3_q[2]) begin
               hi_d = w_div_rem;
               lo_d = {lo_q[30:0], w_div_bit};
            end else begin
               {hi_d, lo_d} = {w_mul_sum, lo_q[31:1]};
            end
            if (cnt_q == 5'd31) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            result_d = w_fix_result;
            rd_out_d = rd_q;
            done_d   = 1'b1;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 5'd0;
         funct3_q <= 3'd0;
         rd_q     <= 5'd0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         result_q <= 32'd0;
         rd_out_q <= 5'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         funct3_q <= funct3_d;
         rd_q     <= rd_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         a_q      <= a_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
         done_q   <= done_d;
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign done   = done_q;
   assign result = result_q;
   assign rd_out = rd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed self-checking bench for muldiv_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

   localparam logic [2:0] c_f3_mul    = 3'b000;
   localparam logic [2:0] c_f3_mulh   = 3'b001;
   localparam logic [2:0] c_f3_mulhsu = 3'b010;
   localparam logic [2:0] c_f3_mulhu  = 3'b011;
   localparam logic [2:0] c_f3_div    = 3'b100;
   localparam logic [2:0] c_f3_divu   = 3'b101;
   localparam logic [2:0] c_f3_rem    = 3'b110;
   localparam logic [2:0] c_f3_remu   = 3'b111;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int errors   = 0;
   int checks   = 0;
   int done_cnt = 0;
   int dc0      = 0;

   muldiv_unit u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .rd_in  (rd_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .rd_out (rd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every cycle in which done is high
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op and check busy/done timing and the result; optionally pulse a
   // second start and scramble operands at cycle 10 of the op.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit disturb,
                         input string tag);
      funct3 = f;
      op_a   = a;
      op_b   = b;
      rd_in  = rd;
      start  = 1'b1;
      @(posedge clk);                        // E0
      #1 chk({tag, "/busy_e0"}, {31'd0, busy}, 32'd1);
      #1 start = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         @(posedge clk);
         #2;
         if (disturb && c == 10) begin
            start  = 1'b1;
            funct3 = c_f3_divu;
            op_a   = 32'hDEAD_BEEF;
            op_b   = 32'h0000_0003;
            rd_in  = 5'd31;
         end else if (disturb && c == 11) begin
            start = 1'b0;
         end
      end
      chk({tag, "/done_e32"}, {31'd0, done}, 32'd0);
      @(posedge clk);                        // E33
      #1;
      chk({tag, "/done_e33"}, {31'd0, done}, 32'd1);
      chk({tag, "/result"}, result, exp);
      chk({tag, "/rd_out"}, {27'd0, rd_out}, {27'd0, rd});
      @(posedge clk);                        // E34
      #1;
      chk({tag, "/done_e34"}, {31'd0, done}, 32'd0);
      chk({tag, "/busy_e34"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      funct3 = 3'd0;
      op_a   = 32'd0;
      op_b   = 32'd0;
      rd_in  = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset/busy",   {31'd0, busy}, 32'd0);
      chk("reset/done",   {31'd0, done}, 32'd0);
      chk("reset/result", result, 32'd0);
      chk("reset/rd_out", {27'd0, rd_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #2;

      // Basic multiply
      run_op(c_f3_mul,    32'd7,         32'd6,         5'd5,  32'h0000_002A, 1'b0, "mul7x6");
      // High-word multiplies of all-ones operands
      run_op(c_f3_mulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 1'b0, "mulh");
      run_op(c_f3_mulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 1'b0, "mulhsu");
      run_op(c_f3_mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 1'b0, "mulhu");
      run_op(c_f3_mul,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0001, 1'b0, "mul_ones");
      // Signed and unsigned division
      run_op(c_f3_div,    32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, 1'b0, "div_m7_2");
      run_op(c_f3_rem,    32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, 1'b0, "rem_m7_2");
      run_op(c_f3_divu,   32'd100,       32'd7,         5'd8,  32'd14,        1'b0, "divu100_7");
      run_op(c_f3_remu,   32'd100,       32'd7,         5'd9,  32'd2,         1'b0, "remu100_7");
      // Divide by zero
      run_op(c_f3_div,    32'h1234_5678, 32'd0,         5'd10, 32'hFFFF_FFFF, 1'b0, "div_by0");
      run_op(c_f3_divu,   32'h1234_5678, 32'd0,         5'd11, 32'hFFFF_FFFF, 1'b0, "divu_by0");
      run_op(c_f3_rem,    32'h1234_5678, 32'd0,         5'd12, 32'h1234_5678, 1'b0, "rem_by0");
      run_op(c_f3_remu,   32'h1234_5678, 32'd0,         5'd13, 32'h1234_5678, 1'b0, "remu_by0");
      // Signed overflow
      run_op(c_f3_div,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1'b0, "div_ovf");
      run_op(c_f3_rem,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, 1'b0, "rem_ovf");
      // Destination x0 still computes and pulses done
      run_op(c_f3_rem,    32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd0,  32'hFFFF_FFFE, 1'b0, "rem_rd0");

      // Start while busy is ignored and operand changes mid-op have no effect
      dc0 = done_cnt;
      run_op(c_f3_mul,    32'd7,         32'd6,         5'd5,  32'h0000_002A, 1'b1, "mul_disturb");
      repeat (40) @(posedge clk);
      #1;
      chk("disturb/done_count", done_cnt, dc0 + 1);
      chk("disturb/busy_idle",  {31'd0, busy}, 32'd0);

      // Asynchronous reset in the middle of a divide
      funct3 = c_f3_div;
      op_a   = 32'd1000;
      op_b   = 32'd3;
      rd_in  = 5'd20;
      start  = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (19) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid/busy",   {31'd0, busy}, 32'd0);
      chk("rst_mid/done",   {31'd0, done}, 32'd0);
      chk("rst_mid/result", result, 32'd0);
      chk("rst_mid/rd_out", {27'd0, rd_out}, 32'd0);
      dc0 = done_cnt;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("rst_mid/no_done", done_cnt, dc0);
      #1;
      run_op(c_f3_divu,   32'd100,       32'd7,         5'd21, 32'd14,        1'b0, "after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
